qdiv_seq: RTL and testbench

//  Sequential sign-magnitude fixed-point divider (N bits, Q fractional bits), the inverse of qmult.

---
 rtl/qdiv_seq.sv | 110 +++++++++++
 tb/tb_qdiv_seq.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/qdiv_seq.sv
// Sequential sign-magnitude Q-format divider: restoring division, one quotient bit per clock.
// Divide-by-zero completes in one cycle with a saturated result and ovr set.
module qdiv_seq #(
    parameter int Q = 15,
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] i_dividend,
    input  logic [N-1:0] i_divisor,
    input  logic         i_start,
    output logic [N-1:0] o_quotient,
    output logic         o_complete,
    output logic         o_busy,
    output logic         ovr
);

    localparam int unsigned NUM_W = N - 1 + Q;
    localparam int unsigned CNT_W = $clog2(N + Q);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_CALC = 1'b1
    } state_t;

    state_t             r_state;
    logic [NUM_W-1:0]   r_num;
    logic [NUM_W-1:0]   r_qm;
    logic [N-1:0]       r_rem;
    logic [N-2:0]       r_div;
    logic               r_sign;
    logic [CNT_W-1:0]   r_cnt;

    logic               w_sign_in;
    logic               w_div_zero;
    logic [N-1:0]       w_rem_sh;
    logic               w_ge;
    logic [N-1:0]       w_rem_nxt;
    logic [NUM_W-1:0]   w_qm_nxt;
    logic               w_ovf;
    logic [N-2:0]       w_mag;
    logic               w_sign_out;

    // One restoring step; the remainder stays below d, so its MSB is always free for the shift.
    always_comb begin
        w_sign_in  = i_dividend[N-1] ^ i_divisor[N-1];
        w_div_zero = (i_divisor[N-2:0] == '0);
        w_rem_sh   = {r_rem[N-2:0], r_num[NUM_W-1]};
        w_ge       = (w_rem_sh >= {1'b0, r_div});
        w_rem_nxt  = w_ge ? (w_rem_sh - {1'b0, r_div}) : w_rem_sh;
        w_qm_nxt   = {r_qm[NUM_W-2:0], w_ge};
        w_ovf      = |w_qm_nxt[NUM_W-1:N-1];
        w_mag      = w_ovf ? {(N-1){1'b1}} : w_qm_nxt[N-2:0];
        w_sign_out = r_sign & (|w_mag);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_num      <= '0;
            r_qm       <= '0;
            r_rem      <= '0;
            r_div      <= '0;
            r_sign     <= 1'b0;
            r_cnt      <= '0;
            o_quotient <= '0;
            o_complete <= 1'b0;
            o_busy     <= 1'b0;
            ovr        <= 1'b0;
        end else begin
            o_complete <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        if (w_div_zero) begin
                            o_quotient <= {w_sign_in, {(N-1){1'b1}}};
                            ovr        <= 1'b1;
                            o_complete <= 1'b1;
                        end else begin
                            r_sign  <= w_sign_in;
                            r_num   <= {i_dividend[N-2:0], {Q{1'b0}}};
                            r_div   <= i_divisor[N-2:0];
                            r_rem   <= '0;
                            r_qm    <= '0;
                            r_cnt   <= CNT_W'(N + Q - 1);
                            o_busy  <= 1'b1;
                            r_state <= S_CALC;
                        end
                    end
                end
                S_CALC: begin
                    r_rem <= w_rem_nxt;
                    r_num <= {r_num[NUM_W-2:0], 1'b0};
                    r_qm  <= w_qm_nxt;
                    r_cnt <= r_cnt - CNT_W'(1);
                    // Final bit: form the saturated, sign-corrected result in the same cycle.
                    if (r_cnt == CNT_W'(1)) begin
                        o_quotient <= {w_sign_out, w_mag};
                        ovr        <= w_ovf;
                        o_complete <= 1'b1;
                        o_busy     <= 1'b0;
                        r_state    <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_qdiv_seq.sv
// Self-checking bench for qdiv_seq: directed vectors, handshake/reset sequences, random ops vs. arithmetic model.
module tb_qdiv_seq;

    logic        clk;
    logic        rst;
    logic [31:0] i_dividend;
    logic [31:0] i_divisor;
    logic        i_start;
    logic [31:0] o_quotient;
    logic        o_complete;
    logic        o_busy;
    logic        ovr;

    int checks;
    int failures;

    qdiv_seq #(.Q(15), .N(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .i_dividend (i_dividend),
        .i_divisor  (i_divisor),
        .i_start    (i_start),
        .o_quotient (o_quotient),
        .o_complete (o_complete),
        .o_busy     (o_busy),
        .ovr        (ovr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] q;
        logic        ov;
        int          lat;
        string       nm;
    } vec_t;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    // Reference: plain integer division of the scaled magnitudes, then saturate.
    function automatic void model(input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] q, output logic ov, output int lat);
        longint unsigned ma, mb, qq;
        logic s;
        ma = 64'(a[30:0]);
        mb = 64'(b[30:0]);
        s  = a[31] ^ b[31];
        if (mb == 0) begin
            q = {s, 31'h7FFF_FFFF}; ov = 1'b1; lat = 1;
        end else begin
            qq  = (ma * 64'd32768) / mb;
            lat = 47;
            if (qq > 64'h7FFF_FFFF) begin
                ov = 1'b1; qq = 64'h7FFF_FFFF;
            end else begin
                ov = 1'b0;
            end
            q = {s && (qq != 0), qq[30:0]};
        end
    endfunction

    // Called just after a rising edge; returns in the o_complete cycle (or after the bound).
    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic [31:0] eq,
                          input logic eov, input int elat, input string nm);
        int lat;
        i_dividend = a;
        i_divisor  = b;
        i_start    = 1'b1;
        @(posedge clk); #1;
        i_start    = 1'b0;
        i_dividend = $urandom;
        i_divisor  = $urandom;
        if (elat > 1) chk({nm, "_busy"}, 32'(o_busy), 32'd1);
        lat = 1;
        while (!o_complete && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        chk({nm, "_lat"}, 32'(lat), 32'(elat));
        chk({nm, "_q"}, o_quotient, eq);
        chk({nm, "_ovr"}, 32'(ovr), 32'(eov));
        chk({nm, "_busy_done"}, 32'(o_busy), 32'd0);
    endtask

    vec_t vecs[$];

    initial begin
        logic [31:0] a, b, q;
        logic        ov;
        int          lat;
        int          pulses;

        checks = 0; failures = 0;
        rst = 1'b1; i_start = 1'b0; i_dividend = '0; i_divisor = '0;

        vecs.push_back('{32'h0001_8000, 32'h0001_0000, 32'h0000_C000, 1'b0, 47, "3div2"});
        vecs.push_back('{32'h8000_8000, 32'h0002_0000, 32'h8000_2000, 1'b0, 47, "m1div4"});
        vecs.push_back('{32'h0000_0000, 32'h8000_8000, 32'h0000_0000, 1'b0, 47, "0divm1"});
        vecs.push_back('{32'h0000_8000, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1,  "div0neg"});
        vecs.push_back('{32'h0000_8000, 32'h0000_0000, 32'h7FFF_FFFF, 1'b1, 1,  "div0pos"});
        vecs.push_back('{32'h4000_0000, 32'h0000_4000, 32'h7FFF_FFFF, 1'b1, 47, "ovf_pos"});
        vecs.push_back('{32'h8040_0000, 32'h0000_0001, 32'hFFFF_FFFF, 1'b1, 47, "ovf_neg"});
        vecs.push_back('{32'h0000_8000, 32'h0001_8000, 32'h0000_2AAA, 1'b0, 47, "1div3"});
        vecs.push_back('{32'h8000_0001, 32'h7FFF_FFFF, 32'h0000_0000, 1'b0, 47, "negzero"});
        vecs.push_back('{32'h7FFF_FFFF, 32'h0000_8000, 32'h7FFF_FFFF, 1'b0, 47, "maxdiv1"});

        repeat (3) @(posedge clk);
        #1;
        chk("rst_q", o_quotient, 32'h0);
        chk("rst_complete", 32'(o_complete), 32'd0);
        chk("rst_busy", 32'(o_busy), 32'd0);
        chk("rst_ovr", 32'(ovr), 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        foreach (vecs[i]) begin
            run_op(vecs[i].a, vecs[i].b, vecs[i].q, vecs[i].ov, vecs[i].lat, vecs[i].nm);
            @(posedge clk); #1;
            chk({vecs[i].nm, "_pulse1"}, 32'(o_complete), 32'd0);
        end

        // Start ignored while busy, then a back-to-back start in the completion cycle.
        i_dividend = 32'h0001_8000; i_divisor = 32'h0001_0000; i_start = 1'b1;
        @(posedge clk); #1;
        pulses = 0;
        for (int c = 1; c < 47; c++) begin
            if (o_complete) pulses++;
            if (c == 10) begin
                i_start = 1'b1; i_dividend = 32'h0005_0000; i_divisor = 32'h0000_8000;
            end else begin
                i_start = 1'b0;
            end
            @(posedge clk); #1;
        end
        chk("hs_early_pulses", 32'(pulses), 32'd0);
        chk("hs_complete47", 32'(o_complete), 32'd1);
        chk("hs_q", o_quotient, 32'h0000_C000);
        i_dividend = 32'h8000_8000; i_divisor = 32'h0002_0000; i_start = 1'b1;
        @(posedge clk); #1;
        i_start = 1'b0;
        pulses = 0;
        for (int c = 1; c < 47; c++) begin
            if (o_complete) pulses++;
            @(posedge clk); #1;
        end
        chk("b2b_early_pulses", 32'(pulses), 32'd0);
        chk("b2b_complete94", 32'(o_complete), 32'd1);
        chk("b2b_q", o_quotient, 32'h8000_2000);
        @(posedge clk); #1;
        chk("b2b_single_pulse", 32'(o_complete), 32'd0);

        // Reset mid-operation aborts without a completion pulse.
        i_dividend = 32'h0001_8000; i_divisor = 32'h0001_0000; i_start = 1'b1;
        @(posedge clk); #1;
        i_start = 1'b0;
        for (int c = 1; c < 20; c++) begin
            @(posedge clk); #1;
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("mrst_busy", 32'(o_busy), 32'd0);
        chk("mrst_q", o_quotient, 32'h0);
        chk("mrst_ovr", 32'(ovr), 32'd0);
        pulses = 0;
        for (int c = 21; c < 52; c++) begin
            if (o_complete) pulses++;
            @(posedge clk); #1;
        end
        chk("mrst_no_pulse", 32'(pulses), 32'd0);
        run_op(32'h0001_8000, 32'h0001_0000, 32'h0000_C000, 1'b0, 47, "after_rst");
        @(posedge clk); #1;

        // Random operands with varied magnitudes; occasional zero divisor.
        for (int i = 0; i < 40; i++) begin
            a = {1'($urandom), 31'($urandom) >> $urandom_range(0, 30)};
            b = {1'($urandom), 31'($urandom) >> $urandom_range(0, 30)};
            if (i % 13 == 5) b[30:0] = '0;
            model(a, b, q, ov, lat);
            run_op(a, b, q, ov, lat, $sformatf("rnd%0d", i));
            if (i % 3 == 0) begin
                @(posedge clk); #1;
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
